// File: rtl/fp_add_normalize_round_if.sv
// Handshake bundle between the adder datapath, this normalize/round stage and its consumer.
// The stage connects through the slave modport; the producer/consumer side uses master.
interface fp_add_normalize_round_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic [2:0]  in_grs;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow
    );
endinterface

// File: rtl/fp_add_normalize_round.sv
// Normalize-and-round stage for the single-precision adder: takes the raw sum, exponent and
// GRS bits, left/right normalizes in bounded steps, rounds to nearest-even and flags over/underflow.
module fp_add_normalize_round #(
    parameter int SHIFT_STEP = 4,
    parameter int EXP_W      = 10
) (
    input  logic                      CLK,
    input  logic                      nRST,
    fp_add_normalize_round_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    localparam logic [4:0]              C_STEP    = 5'(SHIFT_STEP);
    localparam logic signed [EXP_W-1:0] C_ONE     = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] C_EXP_MAX = EXP_W'(255);

    state_t                  r_state, w_state_nxt;
    logic [27:0]             r_w, w_w_nxt;
    logic signed [EXP_W-1:0] r_exp, w_exp_nxt;
    logic                    r_sign, w_sign_nxt;
    logic [31:0]             r_result, w_result_nxt;
    logic                    r_ovf, w_ovf_nxt;
    logic                    r_unf, w_unf_nxt;

    logic [4:0]              w_lz;
    logic [4:0]              w_sh;
    logic [EXP_W-1:0]        w_sh_ext;
    logic signed [EXP_W-1:0] w_exp_shl;
    logic                    w_round_up;
    logic [24:0]             w_rounded;
    logic signed [EXP_W-1:0] w_exp_rnd;
    logic [22:0]             w_frac_rnd;

    // Distance from bit 26 down to the highest set bit of the lower 27 bits (27 when all zero).
    function automatic logic [4:0] f_lzc(input logic [26:0] v);
        logic [4:0] lz;
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lz = 5'(26 - i);
        end
        return lz;
    endfunction

    assign w_lz      = f_lzc(r_w[26:0]);
    assign w_sh      = (w_lz < C_STEP) ? w_lz : C_STEP;
    assign w_sh_ext  = EXP_W'(w_sh);
    assign w_exp_shl = r_exp - $signed(w_sh_ext);

    // Ties-to-even: guard set and anything else set below it, or an odd LSB.
    assign w_round_up = r_w[2] & (r_w[1] | r_w[0] | r_w[3]);
    assign w_rounded  = {1'b0, r_w[26:3]} + {24'd0, w_round_up};
    assign w_exp_rnd  = w_rounded[24] ? (r_exp + C_ONE) : r_exp;
    assign w_frac_rnd = w_rounded[24] ? w_rounded[23:1] : w_rounded[22:0];

    always_comb begin
        // NOTE: every next-state value defaults to its register so no path infers a latch.
        w_state_nxt  = r_state;
        w_w_nxt      = r_w;
        w_exp_nxt    = r_exp;
        w_sign_nxt   = r_sign;
        w_result_nxt = r_result;
        w_ovf_nxt    = r_ovf;
        w_unf_nxt    = r_unf;

        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_w_nxt     = {bus.in_mant, bus.in_grs};
                    w_exp_nxt   = $signed({{(EXP_W-8){1'b0}}, bus.in_exp});
                    w_sign_nxt  = bus.in_sign;
                    w_state_nxt = S_NORM;
                end
            end

            S_NORM: begin
                if (r_w[27:3] == 25'd0) begin
                    w_result_nxt = 32'h0;
                    w_ovf_nxt    = 1'b0;
                    w_unf_nxt    = 1'b0;
                    w_state_nxt  = S_DONE;
                end else if (r_w[27]) begin
                    w_w_nxt      = {1'b0, r_w[27:1]};
                    w_w_nxt[0]   = r_w[1] | r_w[0];
                    w_exp_nxt    = r_exp + C_ONE;
                    w_state_nxt  = S_ROUND;
                end else if (r_w[26]) begin
                    w_state_nxt  = S_ROUND;
                end else if (w_exp_shl < C_ONE) begin
                    w_result_nxt = {r_sign, 31'h0};
                    w_ovf_nxt    = 1'b0;
                    w_unf_nxt    = 1'b1;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_w_nxt      = r_w << w_sh;
                    w_exp_nxt    = w_exp_shl;
                    w_state_nxt  = (w_lz == w_sh) ? S_ROUND : S_NORM;
                end
            end

            S_ROUND: begin
                w_ovf_nxt = 1'b0;
                w_unf_nxt = 1'b0;
                if (w_exp_rnd >= C_EXP_MAX) begin
                    w_result_nxt = {r_sign, 8'hFF, 23'h0};
                    w_ovf_nxt    = 1'b1;
                end else if (w_exp_rnd < C_ONE) begin
                    w_result_nxt = {r_sign, 31'h0};
                    w_unf_nxt    = 1'b1;
                end else begin
                    w_result_nxt = {r_sign, w_exp_rnd[7:0], w_frac_rnd};
                end
                w_exp_nxt   = w_exp_rnd;
                w_state_nxt = S_DONE;
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    w_ovf_nxt   = 1'b0;
                    w_unf_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_result <= 32'h0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            // NOTE: the working registers are cleared too so stale operands never reappear after reset.
            r_w      <= '0;
            r_exp    <= '0;
            r_sign   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_ovf    <= w_ovf_nxt;
            r_unf    <= w_unf_nxt;
            r_w      <= w_w_nxt;
            r_exp    <= w_exp_nxt;
            r_sign   <= w_sign_nxt;
        end
    end

    assign bus.in_ready      = (r_state == S_IDLE);
    assign bus.out_valid     = (r_state == S_DONE);
    assign bus.out_result    = r_result;
    assign bus.out_overflow  = r_ovf;
    assign bus.out_underflow = r_unf;
endmodule
